srio_dma_comb_v2: RTL and testbench

- Parametrised successor to the SRIO DMA combiner. It merges a run of num_pkts AXI-Stream packets arriving on the slave port into a single master-side stream.
- When HDR_EN=1, each packet is prefixed with one header beat carrying its TUSER word.
- Only the final beat of the final packet asserts M_AXIS_TLAST.
- Sits between the SRIO user-port receive path and the DMA S2MM engine. Adds width generalisation, a 2-entry input skid buffer for full throughput, an optional header mode, rearm, zero-count error reporting and a packet counter in status.

---
 rtl/srio_dma_comb_pkg.sv | 20 ++
 rtl/srio_dma_comb_skid.sv | 47 ++++
 rtl/srio_dma_comb_v2.sv | 155 +++++++++++++++
 tb/tb_srio_dma_comb_v2.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srio_dma_comb_pkg.sv
// Shared encodings for the SRIO DMA combiner: FSM states, cmd and status bit positions.
package srio_dma_comb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_HDR = 2'd1,
        RUN_DAT = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int CMD_EN   = 0;
    localparam int CMD_SRST = 1;

    localparam int ST_DONE     = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_ZERO_ERR = 2;
    localparam int ST_CNT_LSB  = 8;
    localparam int ST_CNT_W    = 24;

endpackage

// File: rtl/srio_dma_comb_skid.sv
// Two-entry register slice: entry 0 is always the head presented downstream.
module srio_dma_comb_skid #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [PAYLOAD_W-1:0] data_i,
    output logic [PAYLOAD_W-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [PAYLOAD_W-1:0] mem_q [2];
    logic [1:0]           cnt_q;

    always_ff @(posedge clk) begin
        if (srst || flush_i) begin
            cnt_q <= '0;
        end else begin
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (pop_i) begin
            mem_q[0] <= (cnt_q == 2'd2) ? mem_q[1] : data_i;
        end else if (push_i && cnt_q == 2'd0) begin
            mem_q[0] <= data_i;
        end
        if (push_i && ((cnt_q == 2'd1 && !pop_i) || (cnt_q == 2'd2 && pop_i))) begin
            mem_q[1] <= data_i;
        end
    end

    assign data_o  = mem_q[0];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/srio_dma_comb_v2.sv
// Merges num_pkts AXI-Stream packets into one master stream, optionally prefixing
// each packet with a header beat built from its TUSER word.
module srio_dma_comb_v2
    import srio_dma_comb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int USER_W = 32,
    parameter int CNT_W  = 32,
    parameter bit HDR_EN = 1'b1
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESET,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TLAST,
    input  logic [USER_W-1:0] S_AXIS_TUSER,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    input  logic [31:0]       cmd,
    input  logic [CNT_W-1:0]  num_pkts,
    output logic [31:0]       status
);

    localparam int PW = DATA_W + 1 + USER_W + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   cnt_lat_q, cnt_lat_d;
    logic               zero_err_q, zero_err_d;
    logic               first_q;

    logic               rst, soft_rst, run, final_pkt;
    logic               s_hs, pop, full, empty;
    logic [PW-1:0]      push_word, head_word;
    logic [DATA_W-1:0]  head_data;
    logic               head_last, head_first;
    logic [USER_W-1:0]  head_user;
    logic [ST_CNT_W-1:0] cnt_field;
    logic               unused_bits;

    assign soft_rst = cmd[CMD_SRST];
    assign rst      = AXIS_ARESET | soft_rst;
    assign run      = (state_q == RUN_HDR) || (state_q == RUN_DAT);

    assign S_AXIS_TREADY = run && !full;
    assign s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pop           = (state_q == RUN_DAT) && M_AXIS_TVALID && M_AXIS_TREADY;
    assign final_pkt     = (pkt_cnt_q == cnt_lat_q - CNT_W'(1));

    assign push_word = {S_AXIS_TDATA, S_AXIS_TLAST, S_AXIS_TUSER, first_q};
    assign {head_data, head_last, head_user, head_first} = head_word;

    srio_dma_comb_skid #(
        .PAYLOAD_W (PW)
    ) u_skid (
        .clk     (AXIS_ACLK),
        .srst    (AXIS_ARESET),
        .flush_i (soft_rst),
        .push_i  (s_hs),
        .pop_i   (pop),
        .data_i  (push_word),
        .data_o  (head_word),
        .full_o  (full),
        .empty_o (empty)
    );

    // Tracks packet boundaries on the input side so each entry knows if it opens a packet.
    always_ff @(posedge AXIS_ACLK) begin
        if (rst) begin
            first_q <= 1'b1;
        end else if (s_hs) begin
            first_q <= S_AXIS_TLAST;
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (rst) begin
            state_q    <= IDLE;
            pkt_cnt_q  <= '0;
            cnt_lat_q  <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_cnt_q  <= pkt_cnt_d;
            cnt_lat_q  <= cnt_lat_d;
            zero_err_q <= zero_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pkt_cnt_d     = pkt_cnt_q;
        cnt_lat_d     = cnt_lat_q;
        zero_err_d    = zero_err_q;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TLAST  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd[CMD_EN]) begin
                    if (num_pkts != '0) begin
                        cnt_lat_d = num_pkts;
                        state_d   = HDR_EN ? RUN_HDR : RUN_DAT;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            RUN_HDR: begin
                M_AXIS_TVALID              = !empty;
                M_AXIS_TDATA[USER_W-1:0]   = head_user;
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    state_d = RUN_DAT;
                end
            end
            RUN_DAT: begin
                M_AXIS_TVALID = !empty;
                M_AXIS_TDATA  = head_data;
                M_AXIS_TLAST  = !empty && head_last && final_pkt;
                if (M_AXIS_TVALID && M_AXIS_TREADY && head_last) begin
                    if (final_pkt) begin
                        state_d = DONE;
                    end else begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        state_d   = HDR_EN ? RUN_HDR : RUN_DAT;
                    end
                end
            end
            DONE: begin
                if (!cmd[CMD_EN]) begin
                    pkt_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    generate
        if (CNT_W >= ST_CNT_W) begin : g_cnt_trunc
            assign cnt_field = pkt_cnt_q[ST_CNT_W-1:0];
        end else begin : g_cnt_ext
            assign cnt_field = {{(ST_CNT_W-CNT_W){1'b0}}, pkt_cnt_q};
        end
    endgenerate

    assign status = {cnt_field, 5'b0, zero_err_q, run, (state_q == DONE)};

    // Reserved cmd bits and the stored first flag are intentionally not consumed.
    assign unused_bits = ^{cmd[31:2], head_first};

endmodule

// File: tb/tb_srio_dma_comb_v2.sv
// Scoreboard bench for srio_dma_comb_v2: header and concatenation instances share stimulus.
module tb_srio_dma_comb_v2;

    localparam int DW = 64;
    localparam int UW = 32;
    localparam int CW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          areset;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic [UW-1:0] s_tuser;
    logic          m_tready;
    logic [31:0]   cmd_h, cmd_c;
    logic [CW-1:0] num_pkts;
    logic          sel_cat;

    logic          h_s_tready, h_m_tvalid, h_m_tlast;
    logic [DW-1:0] h_m_tdata;
    logic [31:0]   h_status;
    logic          c_s_tready, c_m_tvalid, c_m_tlast;
    logic [DW-1:0] c_m_tdata;
    logic [31:0]   c_status;

    logic          s_tready, m_tvalid, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [31:0]   status;

    assign s_tready = sel_cat ? c_s_tready : h_s_tready;
    assign m_tvalid = sel_cat ? c_m_tvalid : h_m_tvalid;
    assign m_tlast  = sel_cat ? c_m_tlast  : h_m_tlast;
    assign m_tdata  = sel_cat ? c_m_tdata  : h_m_tdata;
    assign status   = sel_cat ? c_status   : h_status;

    srio_dma_comb_v2 #(.DATA_W(DW), .USER_W(UW), .CNT_W(CW), .HDR_EN(1'b1)) u_hdr (
        .AXIS_ACLK(clk), .AXIS_ARESET(areset),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(h_s_tready), .S_AXIS_TDATA(s_tdata),
        .S_AXIS_TLAST(s_tlast), .S_AXIS_TUSER(s_tuser),
        .M_AXIS_TVALID(h_m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(h_m_tdata),
        .M_AXIS_TLAST(h_m_tlast), .cmd(cmd_h), .num_pkts(num_pkts), .status(h_status)
    );

    srio_dma_comb_v2 #(.DATA_W(DW), .USER_W(UW), .CNT_W(CW), .HDR_EN(1'b0)) u_cat (
        .AXIS_ACLK(clk), .AXIS_ARESET(areset),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(c_s_tready), .S_AXIS_TDATA(s_tdata),
        .S_AXIS_TLAST(s_tlast), .S_AXIS_TUSER(s_tuser),
        .M_AXIS_TVALID(c_m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(c_m_tdata),
        .M_AXIS_TLAST(c_m_tlast), .cmd(cmd_c), .num_pkts(num_pkts), .status(c_status)
    );

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    hs_cnt = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    bit    bp_mode = 1'b0;
    bit    sb_en = 1'b1;

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic monitor();
        bit          hold_v = 1'b0;
        logic [DW:0] hold = '0;
        beat_t       e;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            cyc++;
            if (areset || cmd_h[1] || cmd_c[1]) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_valid", {64'd0, m_tvalid}, {64'd0, 1'b1});
                    check("hold_beat", {m_tdata, m_tlast}, hold);
                end
                if (m_tvalid && m_tready) begin
                    hs_cnt++;
                    if (hs_cnt == 1) first_cyc = cyc;
                    last_cyc = cyc;
                    if (sb_en) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_unexpected actual=%h/%b required=none", m_tdata, m_tlast);
                        end else begin
                            e = exp_q.pop_front();
                            $display("beat data=%h last=%b", m_tdata, m_tlast);
                            check("sb_data", {1'b0, m_tdata}, {1'b0, e.data});
                            check("sb_last", {64'd0, m_tlast}, {64'd0, e.last});
                        end
                    end
                    hold_v = 1'b0;
                end else if (m_tvalid) begin
                    hold_v = 1'b1;
                    hold   = {m_tdata, m_tlast};
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_accept();
        bit acc = 1'b0;
        int t = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_ready required=ready");
        end
    endtask

    task automatic send_pkt(input logic [UW-1:0] user, input int n, input logic [DW-1:0] base,
                            input bit last_pkt, input bit hdr, input bit push_exp);
        for (int i = 0; i < n; i++) begin
            if (push_exp) begin
                if (hdr && i == 0) exp_q.push_back('{data: {32'd0, user}, last: 1'b0});
                exp_q.push_back('{data: base + DW'(i), last: last_pkt && (i == n - 1)});
            end
            s_tvalid = 1'b1;
            s_tdata  = base + DW'(i);
            s_tlast  = (i == n - 1);
            s_tuser  = (i == 0) ? user : 32'hDEAD_BEEF;
            wait_accept();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        bit d = 1'b0;
        int t = 0;
        while (!d && t < 500) begin
            @(negedge clk);
            d = status[0];
            t++;
        end
        if (!d) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%h required=done", status);
        end
        check("sb_drained", 65'(exp_q.size()), 65'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rearm_drop();
        cmd_h = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check("rearm_idle_status", {33'd0, status}, {33'd0, 32'h0});
        @(posedge clk);
        #1;
    endtask

    initial begin
        areset   = 1'b1;
        cmd_h    = 32'd0;
        cmd_c    = 32'd0;
        sel_cat  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        num_pkts = '0;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", {64'd0, h_m_tvalid}, 65'd0);
        check("rst_m_tlast",  {64'd0, h_m_tlast},  65'd0);
        check("rst_m_tdata",  {1'b0, h_m_tdata},   65'd0);
        check("rst_s_tready", {64'd0, h_s_tready}, 65'd0);
        check("rst_status",   {33'd0, h_status},   65'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Three packets with headers, sink always ready.
        num_pkts = 3;
        cmd_h    = 32'd1;
        send_pkt(32'hA1, 2, 64'h0000_00A1_0000_0010, 1'b0, 1'b1, 1'b1);
        send_pkt(32'hB2, 1, 64'h0000_00B2_0000_0020, 1'b0, 1'b1, 1'b1);
        send_pkt(32'hC3, 4, 64'h0000_00C3_0000_0030, 1'b1, 1'b1, 1'b1);
        wait_done();
        check("xfer_status", {33'd0, status}, {33'd0, 32'h0000_0201});
        rearm_drop();

        // Same traffic with random sink backpressure.
        bp_mode = 1'b1;
        cmd_h   = 32'd1;
        send_pkt(32'hA1, 2, 64'h0000_00A1_0000_0010, 1'b0, 1'b1, 1'b1);
        send_pkt(32'hB2, 1, 64'h0000_00B2_0000_0020, 1'b0, 1'b1, 1'b1);
        send_pkt(32'hC3, 4, 64'h0000_00C3_0000_0030, 1'b1, 1'b1, 1'b1);
        wait_done();
        check("bp_status", {33'd0, status}, {33'd0, 32'h0000_0201});
        bp_mode = 1'b0;

        // Rearm from DONE straight into a one-packet transfer.
        rearm_drop();
        num_pkts = 1;
        cmd_h    = 32'd1;
        send_pkt(32'h55, 2, 64'h0000_0055_0000_0050, 1'b1, 1'b1, 1'b1);
        wait_done();
        check("rearm_status", {33'd0, status}, {33'd0, 32'h0000_0001});
        rearm_drop();

        // Concatenation instance: 3+3 beats back to back, no headers.
        sel_cat  = 1'b1;
        num_pkts = 2;
        cmd_c    = 32'd1;
        hs_cnt   = 0;
        send_pkt(32'h11, 3, 64'h0000_0011_0000_0060, 1'b0, 1'b0, 1'b1);
        send_pkt(32'h22, 3, 64'h0000_0022_0000_0070, 1'b1, 1'b0, 1'b1);
        wait_done();
        check("cat_beats",  65'(hs_cnt), 65'd6);
        check("cat_span",   65'(last_cyc - first_cyc), 65'd5);
        check("cat_status", {33'd0, status}, {33'd0, 32'h0000_0101});
        cmd_c = 32'd0;
        @(posedge clk);
        #1;
        sel_cat = 1'b0;

        // Zero packet count: sticky error, no transfer, cleared by soft reset.
        num_pkts = 0;
        cmd_h    = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("zero_status", {33'd0, status},     {33'd0, 32'h0000_0004});
        check("zero_tready", {64'd0, s_tready},   65'd0);
        @(posedge clk);
        #1;
        cmd_h = 32'd2;
        @(posedge clk);
        #1;
        cmd_h = 32'd0;
        @(negedge clk);
        check("zero_clr_status", {33'd0, status}, 65'd0);
        @(posedge clk);
        #1;

        // Abort in the middle of packet 2 of 3, then a clean single-packet transfer.
        sb_en    = 1'b0;
        num_pkts = 3;
        cmd_h    = 32'd1;
        send_pkt(32'hA1, 2, 64'h0000_00A1_0000_0010, 1'b0, 1'b1, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 64'h0000_00B2_0000_0020;
        s_tlast  = 1'b0;
        s_tuser  = 32'hB2;
        wait_accept();
        s_tvalid = 1'b0;
        cmd_h    = 32'd2;
        @(posedge clk);
        #1;
        cmd_h = 32'd0;
        @(negedge clk);
        check("abort_m_tvalid", {64'd0, m_tvalid}, 65'd0);
        check("abort_s_tready", {64'd0, s_tready}, 65'd0);
        check("abort_status",   {33'd0, status},   65'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        sb_en    = 1'b1;
        num_pkts = 1;
        cmd_h    = 32'd1;
        send_pkt(32'hD4, 2, 64'h0000_00D4_0000_0080, 1'b1, 1'b1, 1'b1);
        wait_done();
        check("abort_rearm_status", {33'd0, status}, {33'd0, 32'h0000_0001});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
